// File: rtl/prealpha_accumulator.sv
// Block accumulator for upstream multiplier products: sums BLOCK_SIZE samples, then holds the sum for a handshake.
// Optional clamping arithmetic and sticky out_sat flag enabled by defining PREALPHA_ACC_SATURATION_EN.
module prealpha_accumulator #(
    parameter int unsigned DATA_WIDTH = 34,
    parameter int unsigned ACC_WIDTH  = 48,
    parameter int unsigned BLOCK_SIZE = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sat
);

    localparam int unsigned CW = $clog2(BLOCK_SIZE + 1);
    localparam logic [CW-1:0] BLOCK_LAST = CW'(BLOCK_SIZE);

    typedef enum logic {
        ST_ACC,
        ST_HOLD
    } state_t;

    state_t                       state, state_n;
    logic [CW-1:0]                cnt, cnt_n;
    logic signed [ACC_WIDTH-1:0]  acc, acc_n;
    logic signed [ACC_WIDTH-1:0]  ext;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic                         xfer_in, xfer_out;

`ifdef PREALPHA_ACC_SATURATION_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic                         sat, sat_n;
    logic                         ovf;
    logic [ACC_WIDTH:0]           sum_wide;

    // One guard bit: overflow when the two top bits of the widened sum disagree.
    always_comb begin
        sum_wide = {acc[ACC_WIDTH-1], acc} + {ext[ACC_WIDTH-1], ext};
        ovf      = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
        if (!ovf) begin
            sum = sum_wide[ACC_WIDTH-1:0];
        end else if (sum_wide[ACC_WIDTH]) begin
            sum = ACC_MIN;
        end else begin
            sum = ACC_MAX;
        end
    end

    assign out_sat = sat;
`else
    always_comb begin
        sum = acc + ext;
    end

    assign out_sat = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_ACC;
            cnt   <= '0;
            acc   <= '0;
`ifdef PREALPHA_ACC_SATURATION_EN
            sat   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            acc   <= acc_n;
`ifdef PREALPHA_ACC_SATURATION_EN
            sat   <= sat_n;
`endif
        end
    end

    always_comb begin
        ext       = ACC_WIDTH'($signed(in_data));
        in_ready  = state == ST_ACC;
        out_valid = state == ST_HOLD;
        xfer_in   = in_ready && in_valid;
        xfer_out  = out_valid && out_ready;
        state_n   = state;
        cnt_n     = cnt;
        acc_n     = acc;
`ifdef PREALPHA_ACC_SATURATION_EN
        sat_n     = sat;
`endif
        if (clear) begin
            state_n = ST_ACC;
            cnt_n   = '0;
            acc_n   = '0;
`ifdef PREALPHA_ACC_SATURATION_EN
            sat_n   = 1'b0;
`endif
        end else if (xfer_out) begin
            state_n = ST_ACC;
            cnt_n   = '0;
        end else if (xfer_in) begin
            // First sample of a block loads, so the held result survives until then.
            if (cnt == '0) begin
                acc_n = ext;
`ifdef PREALPHA_ACC_SATURATION_EN
                sat_n = 1'b0;
`endif
            end else begin
                acc_n = sum;
`ifdef PREALPHA_ACC_SATURATION_EN
                sat_n = sat | ovf;
`endif
            end
            cnt_n = cnt + 1'b1;
            if (cnt_n == BLOCK_LAST) begin
                state_n = ST_HOLD;
            end
        end
    end

    assign out_data = acc;

endmodule

// File: doc/prealpha_accumulator.md
PREALPHA_ACCUMULATOR -- requirements
Module: prealpha_accumulator

Interface
REQ-001 Parameter DATA_WIDTH, default 34: width of the signed product word consumed from the upstream multiplier.
REQ-002 Parameter ACC_WIDTH, default 48: width of the signed accumulator and result; must be >= DATA_WIDTH.
REQ-003 Parameter BLOCK_SIZE, default 256: number of products summed per result; must be >= 1.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous clear; discards the partial block and any pending result.
REQ-007 in_data  input  DATA_WIDTH  signed product word (upstream P output).
REQ-008 in_valid  input  1  in_data holds a valid product this cycle.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 out_data  output  ACC_WIDTH  signed block sum.
REQ-011 out_valid  output  1  out_data holds a completed block sum.
REQ-012 out_ready  input  1  downstream accepts out_data this cycle.
REQ-013 out_sat  output  1  the current result saturated at least once (SATURATION_EN only).

Function
REQ-014 Two states: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 Input transfer occurs on a rising edge with in_valid=1 and in_ready=1; output transfer occurs with out_valid=1 and out_ready=1.
REQ-016 Each input transfer adds sign-extended in_data to the accumulator and increments a sample counter of width clog2(BLOCK_SIZE+1).
REQ-017 The first transfer of a block loads in_data rather than adding it, so no idle clear cycle is needed between blocks.
REQ-018 When the transfer makes the counter equal BLOCK_SIZE, the state moves ACC->HOLD; out_valid is high the following cycle (latency 1 from the last sample).
REQ-019 In HOLD, out_data and out_sat remain stable until the output transfer; in_valid is ignored.
REQ-020 An output transfer moves HOLD->ACC, zeroes the counter, and raises in_ready the next cycle; out_data keeps its last value until it is overwritten.
REQ-021 BLOCK_SIZE=1: every input transfer enters HOLD directly.
REQ-022 Without saturation, arithmetic wraps modulo 2^ACC_WIDTH.
REQ-023 clear=1 takes priority over all transfers: next state ACC, counter 0, accumulator 0, out_sat 0; a simultaneous input or output transfer is discarded.
REQ-024 in_valid=0 in ACC holds all state (gaps of any length are allowed mid-block).

Reset
REQ-025 With rst low, the block immediately enters ACC with counter 0, out_data 0, out_valid 0, and out_sat 0.
REQ-026 After rst releases, in_ready is 1; asserting rst mid-block or in HOLD discards all state without producing a result.

Configuration
REQ-027 Macro PREALPHA_ACC_SATURATION_EN: when defined, each addition clamps to the signed limits 2^(ACC_WIDTH-1)-1 and -2^(ACC_WIDTH-1) on overflow, and out_sat becomes a sticky per-block flag.
REQ-028 Macro PREALPHA_ACC_SATURATION_EN: when undefined, arithmetic wraps and out_sat is tied to 0.

Verification
REQ-029 BLOCK_SIZE=4; inputs 156, 2091, 540, 15 on back-to-back cycles, then out_ready=1 -> out_data=2802 one cycle after the 4th sample, with a single out_valid pulse.
REQ-030 Same block with out_ready=0 for 5 cycles and in_valid=1 held -> in_ready=0, out_data=2802 stable, and no input consumed until the out_ready handshake.
REQ-031 BLOCK_SIZE=4; inputs 156, -2091, gap of 3 cycles, then 540, -15 -> out_data=-1410.
REQ-032 BLOCK_SIZE=4; clear asserted after 2 samples, then 6, 6, 6, 6 -> out_data=24 with no earlier out_valid.
REQ-033 DATA_WIDTH=34, ACC_WIDTH=35, BLOCK_SIZE=3; three inputs of 8589934591 -> with the macro, out_data=17179869183 and out_sat=1; without it, out_data=-8589934595 and out_sat=0.
REQ-034 rst asserted in HOLD -> out_valid=0 immediately; next block of 1, 2, 3, 4 -> out_data=10.
